// File: rtl/stack_ptr_unit_pkg.sv
// Shared encodings for the stack pointer unit: operation codes, fault codes
// and FSM state values.
package stack_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_CALL  = 3'b011;
    localparam logic [2:0] OP_RET   = 3'b100;
    localparam logic [2:0] OP_ALLOC = 3'b101;
    localparam logic [2:0] OP_FREE  = 3'b110;
    localparam logic [2:0] OP_SETSP = 3'b111;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_OVER  = 2'b01;
    localparam logic [1:0] FC_UNDER = 2'b10;
    localparam logic [1:0] FC_RANGE = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MEM   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

endpackage

// File: rtl/stack_ptr_unit_if.sv
// Operation, memory-request and status signals of the stack pointer unit.
// The slave modport is the unit's view; master is the control/memory side.
interface stack_ptr_unit_if #(
    parameter int AW = 32
);

    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_code;
    logic [AW-1:0] op_imm;
    logic          mem_valid;
    logic          mem_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] sp;
    logic [AW-1:0] depth;
    logic          fault;
    logic [1:0]    fault_code;
    logic          fault_clr;

    modport master (
        output op_valid, op_code, op_imm, mem_ready, fault_clr,
        input  op_ready, mem_valid, mem_we, mem_addr, sp, depth, fault, fault_code
    );

    modport slave (
        input  op_valid, op_code, op_imm, mem_ready, fault_clr,
        output op_ready, mem_valid, mem_we, mem_addr, sp, depth, fault, fault_code
    );

endinterface

// File: rtl/stack_ptr_unit_sp_bounds_chk.sv
// Combinational legality check of a stack operation against the current SP.
// Arithmetic is one bit wider than SP so no comparison can wrap.
module sp_bounds_chk
    import stack_pkg::*;
#(
    parameter int            AW          = 32,
    parameter logic [AW-1:0] RESET_SP    = AW'(1023),
    parameter logic [AW-1:0] STACK_LIMIT = AW'(0)
) (
    input  logic [AW-1:0] sp_i,
    input  logic [2:0]    op_code_i,
    input  logic [AW-1:0] op_imm_i,
    output logic          legal_o,
    output logic [1:0]    fault_code_o
);

    logic [AW:0] sp_x;
    logic [AW:0] imm_x;
    logic [AW:0] top_x;
    logic [AW:0] lim_x;

    assign sp_x  = {1'b0, sp_i};
    assign imm_x = {1'b0, op_imm_i};
    assign top_x = {1'b0, RESET_SP};
    assign lim_x = {1'b0, STACK_LIMIT};

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        legal_o      = 1'b1;
        fault_code_o = FC_NONE;
        case (op_code_i)
            OP_PUSH, OP_CALL: begin
                if (sp_x <= lim_x) begin
                    legal_o      = 1'b0;
                    fault_code_o = FC_OVER;
                end
            end
            OP_POP, OP_RET: begin
                if (sp_x >= top_x) begin
                    legal_o      = 1'b0;
                    fault_code_o = FC_UNDER;
                end
            end
            OP_ALLOC: begin
                // sp - imm >= limit, rearranged to avoid a negative intermediate
                if (sp_x < imm_x + lim_x) begin
                    legal_o      = 1'b0;
                    fault_code_o = FC_OVER;
                end
            end
            OP_FREE: begin
                if (sp_x + imm_x > top_x) begin
                    legal_o      = 1'b0;
                    fault_code_o = FC_UNDER;
                end
            end
            OP_SETSP: begin
                if ((imm_x < lim_x) || (imm_x > top_x)) begin
                    legal_o      = 1'b0;
                    fault_code_o = FC_RANGE;
                end
            end
            OP_NOP:  ;
            default: ;
        endcase
    end

endmodule

// File: rtl/stack_ptr_unit.sv
// Architectural stack pointer with bounds-checked updates and a valid/ready
// request port towards the data-memory stage.
module stack_ptr_unit
    import stack_pkg::*;
#(
    parameter int            AW          = 32,
    parameter logic [AW-1:0] RESET_SP    = AW'(1023),
    parameter logic [AW-1:0] STACK_LIMIT = AW'(0)
) (
    input  logic             clk,
    input  logic             rst_n,
    stack_ptr_unit_if.slave  bus
);

    logic [1:0]    state_q,      state_d;
    logic [AW-1:0] sp_q,         sp_d;
    logic          mem_valid_q,  mem_valid_d;
    logic          mem_we_q,     mem_we_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic          fault_q,      fault_d;
    logic [1:0]    fault_code_q, fault_code_d;

    logic          chk_legal;
    logic [1:0]    chk_code;

    sp_bounds_chk #(
        .AW          (AW),
        .RESET_SP    (RESET_SP),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_chk (
        .sp_i         (sp_q),
        .op_code_i    (bus.op_code),
        .op_imm_i     (bus.op_imm),
        .legal_o      (chk_legal),
        .fault_code_o (chk_code)
    );

    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    if (!chk_legal) begin
                        fault_d      = 1'b1;
                        fault_code_d = chk_code;
                        state_d      = ST_FAULT;
                    end else begin
                        case (bus.op_code)
                            OP_PUSH, OP_CALL: begin
                                state_d     = ST_MEM;
                                mem_valid_d = 1'b1;
                                mem_we_d    = 1'b1;
                                mem_addr_d  = sp_q - AW'(1);
                            end
                            OP_POP, OP_RET: begin
                                state_d     = ST_MEM;
                                mem_valid_d = 1'b1;
                                mem_we_d    = 1'b0;
                                mem_addr_d  = sp_q;
                            end
                            OP_ALLOC: sp_d = sp_q - bus.op_imm;
                            OP_FREE:  sp_d = sp_q + bus.op_imm;
                            OP_SETSP: sp_d = bus.op_imm;
                            default:  ;
                        endcase
                    end
                end
            end
            ST_MEM: begin
                // Request fields are held until the handshake; SP moves only then.
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    sp_d        = mem_we_q ? (sp_q - AW'(1)) : (sp_q + AW'(1));
                end
            end
            ST_FAULT: begin
                if (bus.fault_clr) begin
                    state_d      = ST_IDLE;
                    fault_d      = 1'b0;
                    fault_code_d = FC_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sp_q         <= RESET_SP;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign bus.op_ready   = (state_q == ST_IDLE);
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.sp         = sp_q;
    assign bus.depth      = RESET_SP - sp_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Directed bench for stack_ptr_unit: one instance with the default limit and
// one with STACK_LIMIT=1020. Inputs change and outputs are sampled on negedge.
module tb_stack_ptr_unit;
    import stack_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   stable;

    stack_ptr_unit_if #(.AW(32)) a_if ();
    stack_ptr_unit_if #(.AW(32)) b_if ();

    stack_ptr_unit #(
        .AW(32), .RESET_SP(32'd1023), .STACK_LIMIT(32'd0)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    stack_ptr_unit #(
        .AW(32), .RESET_SP(32'd1023), .STACK_LIMIT(32'd1020)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic op_a(input logic [2:0] code, input logic [31:0] imm);
        a_if.op_valid = 1'b1;
        a_if.op_code  = code;
        a_if.op_imm   = imm;
        @(negedge clk);
        a_if.op_valid = 1'b0;
    endtask

    task automatic op_b(input logic [2:0] code, input logic [31:0] imm);
        b_if.op_valid = 1'b1;
        b_if.op_code  = code;
        b_if.op_imm   = imm;
        @(negedge clk);
        b_if.op_valid = 1'b0;
    endtask

    task automatic clr_a();
        a_if.fault_clr = 1'b1;
        @(negedge clk);
        a_if.fault_clr = 1'b0;
    endtask

    task automatic clr_b();
        b_if.fault_clr = 1'b1;
        @(negedge clk);
        b_if.fault_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        a_if.op_valid  = 1'b0; a_if.op_code = OP_NOP; a_if.op_imm = '0;
        a_if.mem_ready = 1'b0; a_if.fault_clr = 1'b0;
        b_if.op_valid  = 1'b0; b_if.op_code = OP_NOP; b_if.op_imm = '0;
        b_if.mem_ready = 1'b0; b_if.fault_clr = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_sp",         a_if.sp, 1023);
        check("rst_depth",      a_if.depth, 0);
        check("rst_mem_valid",  a_if.mem_valid, 0);
        check("rst_mem_we",     a_if.mem_we, 0);
        check("rst_mem_addr",   a_if.mem_addr, 0);
        check("rst_fault",      a_if.fault, 0);
        check("rst_fault_code", a_if.fault_code, 0);
        check("rst_op_ready",   a_if.op_ready, 1);
        check("rst_b_sp",       b_if.sp, 1023);
        rst_n = 1'b1;

        // PUSH with memory always ready
        a_if.mem_ready = 1'b1;
        op_a(OP_PUSH, 0);
        check("push_mem_valid", a_if.mem_valid, 1);
        check("push_mem_we",    a_if.mem_we, 1);
        check("push_mem_addr",  a_if.mem_addr, 1022);
        check("push_op_ready",  a_if.op_ready, 0);
        @(negedge clk);
        check("push_sp",        a_if.sp, 1022);
        check("push_depth",     a_if.depth, 1);
        check("push_done",      a_if.mem_valid, 0);
        check("push_idle",      a_if.op_ready, 1);

        // PUSH then POP with memory stalling 3 cycles each
        do_reset();
        a_if.mem_ready = 1'b0;
        op_a(OP_PUSH, 0);
        stable = 0;
        for (int i = 0; i < 3; i++) begin
            if (a_if.mem_valid && a_if.mem_we && a_if.mem_addr == 32'd1022 && a_if.sp == 32'd1023)
                stable++;
            @(negedge clk);
        end
        check("stall_push_stable", stable, 3);
        a_if.mem_ready = 1'b1;
        @(negedge clk);
        check("stall_push_sp", a_if.sp, 1022);
        a_if.mem_ready = 1'b0;
        op_a(OP_POP, 0);
        stable = 0;
        for (int i = 0; i < 3; i++) begin
            if (a_if.mem_valid && !a_if.mem_we && a_if.mem_addr == 32'd1022 && a_if.sp == 32'd1022)
                stable++;
            @(negedge clk);
        end
        check("stall_pop_stable", stable, 3);
        a_if.mem_ready = 1'b1;
        @(negedge clk);
        check("pop_sp",        a_if.sp, 1023);
        check("pop_mem_addr",  a_if.mem_addr, 1022);
        check("pop_mem_we",    a_if.mem_we, 0);
        check("pop_mem_valid", a_if.mem_valid, 0);

        // POP on empty stack; clear arriving together with a new op
        op_a(OP_POP, 0);
        check("uf_mem_valid", a_if.mem_valid, 0);
        check("uf_fault",     a_if.fault, 1);
        check("uf_code",      a_if.fault_code, 2);
        check("uf_op_ready",  a_if.op_ready, 0);
        a_if.fault_clr = 1'b1;
        a_if.op_valid  = 1'b1;
        a_if.op_code   = OP_PUSH;
        @(negedge clk);
        a_if.fault_clr = 1'b0;
        a_if.op_valid  = 1'b0;
        check("clr_fault",     a_if.fault, 0);
        check("clr_code",      a_if.fault_code, 0);
        check("clr_op_ready",  a_if.op_ready, 1);
        check("clr_no_accept", a_if.mem_valid, 0);
        check("clr_sp",        a_if.sp, 1023);

        // SETSP range and back-to-back single-cycle ops
        op_a(OP_SETSP, 1024);
        check("setsp_hi_fault", a_if.fault_code, 3);
        check("setsp_hi_sp",    a_if.sp, 1023);
        clr_a();
        op_a(OP_SETSP, 1020);
        check("setsp_sp",       a_if.sp, 1020);
        check("setsp_fault",    a_if.fault, 0);
        a_if.op_valid = 1'b1;
        a_if.op_code  = OP_SETSP; a_if.op_imm = 1010;
        @(negedge clk);
        check("b2b_setsp", a_if.sp, 1010);
        a_if.op_code  = OP_ALLOC; a_if.op_imm = 5;
        @(negedge clk);
        check("b2b_alloc", a_if.sp, 1005);
        a_if.op_code  = OP_FREE;  a_if.op_imm = 2;
        @(negedge clk);
        a_if.op_valid = 1'b0;
        check("b2b_free",  a_if.sp, 1007);
        check("b2b_ready", a_if.op_ready, 1);
        op_a(OP_SETSP, 0);
        check("setsp_lim_sp", a_if.sp, 0);
        op_a(OP_CALL, 0);
        check("call_of_code", a_if.fault_code, 1);
        clr_a();
        op_a(OP_ALLOC, 0);
        check("alloc0_lim_sp", a_if.sp, 0);
        op_a(OP_FREE, 1023);
        check("free_exact_sp", a_if.sp, 1023);
        op_a(OP_RET, 0);
        check("ret_uf_code", a_if.fault_code, 2);
        clr_a();

        // Reset while a request is pending
        op_a(OP_SETSP, 1000);
        a_if.mem_ready = 1'b0;
        op_a(OP_PUSH, 0);
        check("pend_addr", a_if.mem_addr, 999);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_valid", a_if.mem_valid, 0);
        check("arst_sp",        a_if.sp, 1023);
        check("arst_addr",      a_if.mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_if.mem_ready = 1'b1;
        op_a(OP_PUSH, 0);
        check("post_rst_addr",  a_if.mem_addr, 1022);
        check("post_rst_valid", a_if.mem_valid, 1);
        @(negedge clk);
        check("post_rst_sp",    a_if.sp, 1022);

        // STACK_LIMIT = 1020 instance
        op_b(OP_ALLOC, 3);
        check("lim_alloc_sp",    b_if.sp, 1020);
        check("lim_alloc_depth", b_if.depth, 3);
        op_b(OP_PUSH, 0);
        check("lim_push_fault",  b_if.fault, 1);
        check("lim_push_code",   b_if.fault_code, 1);
        check("lim_push_nomem",  b_if.mem_valid, 0);
        check("lim_push_sp",     b_if.sp, 1020);
        clr_b();
        op_b(OP_FREE, 4);
        check("lim_free_code",   b_if.fault_code, 2);
        check("lim_free_sp",     b_if.sp, 1020);
        clr_b();
        op_b(OP_SETSP, 1019);
        check("lim_setsp_code",  b_if.fault_code, 3);
        clr_b();
        op_b(OP_ALLOC, 1);
        check("lim_alloc1_code", b_if.fault_code, 1);
        clr_b();
        op_b(OP_FREE, 3);
        check("lim_free3_sp",    b_if.sp, 1023);
        check("lim_free3_fault", b_if.fault, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
